// File: rtl/strobe_sched_pkg.sv
// Shared types and the round-robin search used by the strobe scheduler.
package strobe_sched_pkg;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_t;

    // Widest channel count the search helper handles; callers zero-extend into it.
    localparam int unsigned RR_MAX_CH = 32;
    localparam int unsigned RR_IDX_W  = 5;

    // Returns 1 when a pending bit was found; idx is the first set bit after 'last', wrapping at num_ch.
    function automatic logic rr_pick(
        input  logic [RR_MAX_CH-1:0] pending,
        input  int unsigned          last,
        input  int unsigned          num_ch,
        output int unsigned          idx
    );
        logic        found;
        int unsigned c;
        found = 1'b0;
        idx   = 0;
        c     = 0;
        for (int unsigned i = 1; i <= RR_MAX_CH; i++) begin
            if (i <= num_ch) begin
                c = (last + i) % num_ch;
                if (!found && pending[c[RR_IDX_W-1:0]]) begin
                    found = 1'b1;
                    idx   = c;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/strobe_accum.sv
// One phase-accumulator divider: acc/step/en registers with a synchronous config load.
module strobe_accum
    import strobe_sched_pkg::*;
#(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stb,
    input  logic                 i_load,
    input  logic [ACC_WIDTH-1:0] i_load_step,
    input  logic                 i_load_en,
    output logic                 o_carry,
    output logic                 o_en
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] step_q, step_d;
    logic                 en_q, en_d;
    logic [ACC_WIDTH:0]   sum;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, step_q};
        acc_d   = acc_q;
        step_d  = step_q;
        en_d    = en_q;
        o_carry = 1'b0;
        // A config load wins over accumulation and suppresses the carry.
        if (i_load) begin
            acc_d  = '0;
            step_d = i_load_step;
            en_d   = i_load_en;
        end else if (i_stb && en_q) begin
            acc_d   = sum[ACC_WIDTH-1:0];
            o_carry = sum[ACC_WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q  <= '0;
            step_q <= '0;
            en_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
            en_q   <= en_d;
        end
    end

    assign o_en = en_q;

endmodule

// File: rtl/strobe_scheduler.sv
// Multi-channel strobe scheduler: per-channel dividers, pending queue, round-robin
// output port and a two-state config write path.
module strobe_scheduler
    import strobe_sched_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stb,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [CH_W-1:0]      i_cfg_ch,
    input  logic [ACC_WIDTH-1:0] i_cfg_step,
    input  logic                 i_cfg_en,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CH_W-1:0]      o_ch,
    output logic [NUM_CH-1:0]    o_drop,
    output logic [NUM_CH-1:0]    o_active
);

    logic [NUM_CH-1:0]    pending_q, pending_d;
    logic [NUM_CH-1:0]    drop_q, drop_d;
    logic [NUM_CH-1:0]    carry, en_vec, grant, load;
    logic                 valid_q, valid_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [CH_W-1:0]      last_q, last_d;
    cfg_state_t           cfg_state_q, cfg_state_d;
    logic [CH_W-1:0]      cfg_ch_q, cfg_ch_d;
    logic [ACC_WIDTH-1:0] cfg_step_q, cfg_step_d;
    logic                 cfg_en_q, cfg_en_d;
    logic                 cfg_ready;
    logic                 apply;
    logic                 pick_found;
    int unsigned          pick_idx;

    assign apply = (cfg_state_q == CFG_APPLY);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign load[gi] = apply && (cfg_ch_q == CH_W'(gi));

        strobe_accum #(
            .ACC_WIDTH(ACC_WIDTH)
        ) u_accum (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_stb       (i_stb),
            .i_load      (load[gi]),
            .i_load_step (cfg_step_q),
            .i_load_en   (cfg_en_q),
            .o_carry     (carry[gi]),
            .o_en        (en_vec[gi])
        );
    end

    always_comb begin
        valid_d    = valid_q;
        ch_d       = ch_q;
        last_d     = last_q;
        grant      = '0;
        pick_idx   = 0;
        pick_found = rr_pick(RR_MAX_CH'(pending_q), 32'(last_q), NUM_CH, pick_idx);
        if (!valid_q || i_ready) begin
            valid_d = pick_found;
            if (pick_found) begin
                ch_d        = CH_W'(pick_idx);
                last_d      = CH_W'(pick_idx);
                grant[ch_d] = 1'b1;
            end
        end
        // A carry landing on the channel being granted re-arms it instead of dropping.
        drop_d    = carry & pending_q & ~grant;
        pending_d = (pending_q & ~grant) | carry;
        if (apply && !cfg_en_q) begin
            pending_d[cfg_ch_q] = 1'b0;
        end
    end

    always_comb begin
        cfg_state_d = cfg_state_q;
        cfg_ch_d    = cfg_ch_q;
        cfg_step_d  = cfg_step_q;
        cfg_en_d    = cfg_en_q;
        cfg_ready   = (cfg_state_q == CFG_IDLE) && !i_rst;
        case (cfg_state_q)
            CFG_IDLE: begin
                if (i_cfg_valid && cfg_ready) begin
                    cfg_ch_d    = i_cfg_ch;
                    cfg_step_d  = i_cfg_step;
                    cfg_en_d    = i_cfg_en;
                    cfg_state_d = CFG_APPLY;
                end
            end
            CFG_APPLY: cfg_state_d = CFG_IDLE;
            default:   cfg_state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q   <= '0;
            drop_q      <= '0;
            valid_q     <= 1'b0;
            ch_q        <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            cfg_state_q <= CFG_IDLE;
            cfg_ch_q    <= '0;
            cfg_step_q  <= '0;
            cfg_en_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            drop_q      <= drop_d;
            valid_q     <= valid_d;
            ch_q        <= ch_d;
            last_q      <= last_d;
            cfg_state_q <= cfg_state_d;
            cfg_ch_q    <= cfg_ch_d;
            cfg_step_q  <= cfg_step_d;
            cfg_en_q    <= cfg_en_d;
        end
    end

    assign o_cfg_ready = cfg_ready;
    assign o_valid     = valid_q;
    assign o_ch        = ch_q;
    assign o_drop      = drop_q;
    assign o_active    = en_vec;

endmodule

// File: tb/tb_strobe_scheduler.sv
// Directed bench for strobe_scheduler: vector tables for steady-state streams,
// hand sequences for backpressure, config, and mid-stream reset.
module tb_strobe_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_stb;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [1:0]  i_cfg_ch;
    logic [15:0] i_cfg_step;
    logic        i_cfg_en;
    logic        o_valid;
    logic        i_ready;
    logic [1:0]  o_ch;
    logic [3:0]  o_drop;
    logic [3:0]  o_active;

    int total = 0;
    int bad   = 0;

    strobe_scheduler #(.NUM_CH(4), .ACC_WIDTH(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_stb       (i_stb),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_ch    (i_cfg_ch),
        .i_cfg_step  (i_cfg_step),
        .i_cfg_en    (i_cfg_en),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_ch        (o_ch),
        .o_drop      (o_drop),
        .o_active    (o_active)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       stb;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_ch;
        logic [3:0] exp_drop;
    } vec_t;

    vec_t vecs [20];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic set_vec(input int idx, input logic stb, input logic rdy,
                           input logic v, input logic [1:0] ch, input logic [3:0] drop);
        vecs[idx].stb       = stb;
        vecs[idx].rdy       = rdy;
        vecs[idx].exp_valid = v;
        vecs[idx].exp_ch    = ch;
        vecs[idx].exp_drop  = drop;
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        i_stb       = 1'b0;
        i_ready     = 1'b0;
        i_cfg_valid = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] step, input logic en);
        i_stb = 1'b0;
        chk("cfg_ready_idle", 32'(o_cfg_ready), 32'd1);
        i_cfg_valid = 1'b1;
        i_cfg_ch    = ch;
        i_cfg_step  = step;
        i_cfg_en    = en;
        tick();
        i_cfg_valid = 1'b0;
        chk("cfg_ready_apply", 32'(o_cfg_ready), 32'd0);
        tick();
        chk("cfg_ready_back", 32'(o_cfg_ready), 32'd1);
        $display("cfg write ch=%0d step=%04h en=%0d active=%b", ch, step, en, o_active);
    endtask

    task automatic run_vecs(input string tag, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            i_stb   = vecs[i].stb;
            i_ready = vecs[i].rdy;
            tick();
            $display("%s vec %0d: valid=%0d ch=%0d drop=%b", tag, i, o_valid, o_ch, o_drop);
            chk({tag, "_valid"}, 32'(o_valid), 32'(vecs[i].exp_valid));
            chk({tag, "_ch"},    32'(o_ch),    32'(vecs[i].exp_ch));
            chk({tag, "_drop"},  32'(o_drop),  32'(vecs[i].exp_drop));
        end
    endtask

    task automatic out_chk(input string name, input logic v, input logic [1:0] ch, input logic [3:0] drop);
        $display("%s: valid=%0d ch=%0d drop=%b active=%b", name, o_valid, o_ch, o_drop, o_active);
        chk({name, "_valid"}, 32'(o_valid), 32'(v));
        if (v) chk({name, "_ch"}, 32'(o_ch), 32'(ch));
        chk({name, "_drop"}, 32'(o_drop), 32'(drop));
    endtask

    initial begin
        i_rst = 1'b1; i_stb = 1'b0; i_ready = 1'b0; i_cfg_valid = 1'b0;
        i_cfg_ch = '0; i_cfg_step = '0; i_cfg_en = 1'b0;

        // Single channel, step = 1/4: one grant every 4 strobes, first 2 cycles after the 4th.
        set_vec(0, 1, 1, 0, 0, 4'b0000);
        set_vec(1, 1, 1, 0, 0, 4'b0000);
        set_vec(2, 1, 1, 0, 0, 4'b0000);
        set_vec(3, 1, 1, 0, 0, 4'b0000);
        set_vec(4, 1, 1, 1, 0, 4'b0000);
        set_vec(5, 1, 1, 0, 0, 4'b0000);
        set_vec(6, 1, 1, 0, 0, 4'b0000);
        set_vec(7, 1, 1, 0, 0, 4'b0000);
        set_vec(8, 1, 1, 1, 0, 4'b0000);
        set_vec(9, 0, 1, 0, 0, 4'b0000);
        // All four at step = 1/2: demand twice the port rate, strict rotation, drops on waiting channels.
        set_vec(10, 1, 1, 0, 0, 4'b0000);
        set_vec(11, 1, 1, 0, 0, 4'b0000);
        set_vec(12, 1, 1, 1, 0, 4'b0000);
        set_vec(13, 1, 1, 1, 1, 4'b1100);
        set_vec(14, 1, 1, 1, 2, 4'b0000);
        set_vec(15, 1, 1, 1, 3, 4'b0011);
        set_vec(16, 1, 1, 1, 0, 4'b0000);
        set_vec(17, 1, 1, 1, 1, 4'b1100);
        set_vec(18, 1, 1, 1, 2, 4'b0000);
        set_vec(19, 1, 1, 1, 3, 4'b0011);

        // Reset values
        tick();
        tick();
        chk("rst_valid",     32'(o_valid),     32'd0);
        chk("rst_ch",        32'(o_ch),        32'd0);
        chk("rst_drop",      32'(o_drop),      32'd0);
        chk("rst_active",    32'(o_active),    32'd0);
        chk("rst_cfg_ready", 32'(o_cfg_ready), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_cfg_ready", 32'(o_cfg_ready), 32'd1);

        cfg_write(2'd0, 16'h4000, 1'b1);
        chk("single_active", 32'(o_active), 32'b0001);
        run_vecs("single", 0, 9);

        do_reset();
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 16'h8000, 1'b1);
        chk("rr_active", 32'(o_active), 32'b1111);
        run_vecs("rr", 10, 19);

        // Backpressure on ch2
        do_reset();
        cfg_write(2'd2, 16'h8000, 1'b1);
        i_stb = 1'b1;
        tick();
        tick();
        i_stb = 1'b0;
        tick();
        out_chk("bp_first", 1'b1, 2'd2, 4'b0000);
        for (int j = 0; j < 10; j++) begin
            i_stb = (j == 0 || j == 1 || j == 3 || j == 4);
            tick();
            out_chk($sformatf("bp_stall%0d", j), 1'b1, 2'd2, (j == 4) ? 4'b0100 : 4'b0000);
        end
        i_stb   = 1'b0;
        i_ready = 1'b1;
        tick();
        out_chk("bp_regrant", 1'b1, 2'd2, 4'b0000);
        tick();
        out_chk("bp_empty", 1'b0, 2'd0, 4'b0000);

        // Config: reload clears acc, disabling clears pending
        do_reset();
        cfg_write(2'd1, 16'h8000, 1'b1);
        i_stb = 1'b1;
        tick();
        i_stb = 1'b0;
        out_chk("cfg_pre", 1'b0, 2'd0, 4'b0000);
        cfg_write(2'd1, 16'hFFFF, 1'b1);
        cfg_write(2'd0, 16'h8000, 1'b1);
        chk("cfg_active2", 32'(o_active), 32'b0011);
        i_stb = 1'b1;
        tick();
        out_chk("cfg_acc_cleared", 1'b0, 2'd0, 4'b0000);
        tick();
        out_chk("cfg_f2", 1'b0, 2'd0, 4'b0000);
        i_stb = 1'b0;
        tick();
        out_chk("cfg_f3", 1'b1, 2'd0, 4'b0000);
        cfg_write(2'd1, 16'hFFFF, 1'b0);
        out_chk("cfg_held", 1'b1, 2'd0, 4'b0000);
        chk("cfg_active_dis", 32'(o_active), 32'b0001);
        i_ready = 1'b1;
        tick();
        out_chk("cfg_no_ch1_a", 1'b0, 2'd0, 4'b0000);
        tick();
        out_chk("cfg_no_ch1_b", 1'b0, 2'd0, 4'b0000);

        // Reset with o_valid=1 and pending=1011
        do_reset();
        cfg_write(2'd0, 16'h4000, 1'b1);
        cfg_write(2'd1, 16'h4000, 1'b1);
        cfg_write(2'd2, 16'h5556, 1'b1);
        cfg_write(2'd3, 16'h4000, 1'b1);
        i_stb = 1'b1;
        tick();
        tick();
        tick();
        out_chk("mr_e3", 1'b0, 2'd0, 4'b0000);
        tick();
        i_stb = 1'b0;
        out_chk("mr_e4", 1'b1, 2'd2, 4'b0000);
        i_rst = 1'b1;
        tick();
        out_chk("mr_reset", 1'b0, 2'd0, 4'b0000);
        chk("mr_active", 32'(o_active), 32'd0);
        chk("mr_ch", 32'(o_ch), 32'd0);
        chk("mr_cfg_ready", 32'(o_cfg_ready), 32'd0);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        #1;
        chk("mr_cfg_ready_rel", 32'(o_cfg_ready), 32'd1);
        for (int j = 0; j < 3; j++) begin
            tick();
            out_chk($sformatf("mr_after%0d", j), 1'b0, 2'd0, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/strobe_scheduler.md
# strobe_scheduler

Multi-channel strobe scheduler for the strobe-rate datapath. It holds NUM_CH independently programmable phase-accumulator dividers, all clocked by a common base strobe. It queues each channel's overflow strobe as a pending request and hands pending requests, one at a time, to a single downstream consumer through a round-robin valid/ready port. It sits between the base-rate strobe source and the shared sample/config engine that services one channel per handshake.

## Interface
Parameters:
- NUM_CH, 4: number of channels; power of two, ≥2.
- ACC_WIDTH, 16: accumulator and step width.
- CH_W, $clog2(NUM_CH): channel index width (derived; do not override).

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_stb  in  1  base-rate strobe; one-cycle pulse
- i_cfg_valid  in  1  config write request
- o_cfg_ready  out  1  config write can be accepted
- i_cfg_ch  in  CH_W  channel to configure
- i_cfg_step  in  ACC_WIDTH  new step value
- i_cfg_en  in  1  new enable value
- o_valid  out  1  a channel strobe is presented
- i_ready  in  1  consumer accepts o_ch
- o_ch  out  CH_W  channel index of the presented strobe
- o_drop  out  NUM_CH  one-cycle mask of channels whose strobe was lost
- o_active  out  NUM_CH  current enable bit per channel

## Operation
- Per channel c: registers acc[c], step[c], en[c], pending[c]. All reset to 0.
- On a cycle with i_stb=1 and en[c]=1, the accumulator updates as {carry, acc[c]} <= acc[c] + step[c], computed ACC_WIDTH+1 bits wide.
  - carry=1 sets pending[c].
  - Resulting rate is i_stb rate × step/2^ACC_WIDTH. step=0 never fires.
- Drop rule: if carry=1 on channel c while pending[c]=1 and c is not being granted that cycle, then bit c of o_drop is 1 on the next cycle. pending stays 1, so there is no double count.
- Grant/carry collision: if the channel being granted in this cycle also produces a carry, pending[c] stays 1 and no drop is reported.
- Arbiter:
  - Whenever o_valid=0 or i_ready=1, select the first c with pending[c]=1, searching from last_grant+1 and wrapping modulo NUM_CH.
  - On a selection, register o_ch=c and o_valid=1, clear pending[c], and set last_grant=c.
  - If nothing is pending, o_valid<=0.
  - last_grant resets to NUM_CH-1, so channel 0 is searched first.
- Config FSM with states CFG_IDLE and CFG_APPLY:
  - CFG_IDLE: o_cfg_ready=1. When i_cfg_valid=1, latch ch/step/en and go to CFG_APPLY.
  - CFG_APPLY: o_cfg_ready=0. Write step[ch] and en[ch], force acc[ch]=0, and clear pending[ch] if the new en=0. Return to CFG_IDLE.
  - The APPLY write overrides any i_stb accumulation for that channel in the same cycle. Other channels accumulate normally.
- Disabling a channel whose strobe is already in the output register does not retract it; o_ch stays until accepted.
- o_active mirrors en[].

## Timing
- Reset values:
  - o_valid=0, o_ch=0, o_drop=0, o_active=0.
  - o_cfg_ready=0 while i_rst=1, and 1 from the first cycle after reset deasserts.
  - FSM starts in CFG_IDLE.
- Latency, no contention: i_stb with carry at cycle t → pending at t+1 → o_valid=1 at t+2.
- Config latency: accepted at t, new step in effect for i_stb at t+2 or later. Throughput is one write per 2 cycles.
- Output handshake: o_ch and o_valid stay stable while o_valid=1 and i_ready=0. With i_ready held at 1, the port sustains one grant per cycle.
- o_drop is registered, asserted for exactly one cycle per dropped carry, and several bits may be set at once.
- i_rst mid-operation clears all state on that edge. Pending strobes are discarded without an o_drop report.

## Structure
- Shared package strobe_sched_pkg:
  - cfg_state_t enum {CFG_IDLE, CFG_APPLY}.
  - Function rr_pick(pending, last) that returns the index and a found flag.
- Sub-module strobe_accum, one instance per channel: acc/step/en registers, carry output, synchronous load port for the config write.
- Top level holds the pending[] vector, the arbiter, the output register, the drop logic and the config FSM.

## Test plan
- Single channel: ACC_WIDTH=16, ch0 step=0x4000 en=1, i_stb every cycle, i_ready=1 → o_valid pulses with o_ch=0 once per 4 i_stb. The first grant appears 2 cycles after the 4th i_stb.
- Round-robin: all 4 channels step=0x8000, i_stb every cycle, i_ready=1 → grants in order 0,1,2,3,0,1,… with no channel granted twice before the others. Expect o_drop bits because demand is 2× the port capacity.
- Backpressure: ch2 pending, i_ready=0 for 10 cycles → o_ch=2 held stable with o_valid=1. A second ch2 carry during the stall is held in pending, and a third raises o_drop=4'b0100 one cycle later.
- Config: write ch1 step=0xFFFF en=1 mid-run → o_cfg_ready drops for 1 cycle and acc[1] reads 0 after APPLY. Then write en=0 while pending[1]=1 → pending cleared and no grant for ch1.
- Collision: grant of ch3 and a new carry on ch3 in the same cycle → no drop, and ch3 is presented again at its next round-robin turn.
- Reset mid-stream: assert i_rst with o_valid=1 and pending=4'b1011 → next cycle o_valid=0, pending=0, o_active=0, o_drop=0.
